// File: rtl/sigma_delta_adc.sv
// sigma_delta_adc: first-order sigma-delta front end with a 2nd-order CIC
// decimator (ratio R = 2**DECIM_LOG2) producing 16-bit offset-binary samples.
//
// Ports:
//   clk        - single clock, rising edge
//   reset      - synchronous, active-high reset
//   sd_in      - external comparator output (asynchronous to clk)
//   sd_fb      - feedback drive to the external RC integrator
//   dout       - 16-bit unsigned sample, 0x0000 = full-scale low, 0xFFFF = high
//   dout_valid - one-cycle strobe marking a new dout
module sigma_delta_adc #(
  parameter int unsigned DECIM_LOG2 = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sd_in,
  output logic        sd_fb,
  output logic [15:0] dout,
  output logic        dout_valid
);

  localparam int unsigned W     = 2 * DECIM_LOG2 + 1;
  localparam int unsigned SHIFT = 16 - 2 * DECIM_LOG2;
  localparam int unsigned SW    = 17;
  localparam int unsigned CW    = DECIM_LOG2;

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;
  logic [W-1:0]  i1;
  logic [W-1:0]  i2;
  logic [W-1:0]  i2_d;
  logic [W-1:0]  c1_d;
  logic [1:0]    warm;

  logic          tick_c;
  logic [W-1:0]  c1_c;
  logic [W-1:0]  c2_c;
  logic [SW-1:0] scaled_c;
  logic [15:0]   sat_c;

  // Feedback is the synchronized comparator bit itself.
  assign sd_fb = s2;

  // Tick on the last phase of each decimation period.
  assign tick_c = (cnt == {CW{1'b1}});

  // Comb stages, modulo 2^W; integrator wrap cancels out here.
  assign c1_c = i2 - i2_d;
  assign c2_c = c1_c - c1_d;

  // c2 never exceeds R^2, so only the all-ones case sets bit 16.
  assign scaled_c = SW'(c2_c) << SHIFT;
  assign sat_c    = scaled_c[16] ? 16'hFFFF : scaled_c[15:0];

  // Synchronizer, integrators, comb state, warm-up and output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      cnt        <= '0;
      i1         <= '0;
      i2         <= '0;
      i2_d       <= '0;
      c1_d       <= '0;
      warm       <= 2'd0;
      dout       <= 16'h0000;
      dout_valid <= 1'b0;
    end else begin
      s1         <= sd_in;
      s2         <= s1;
      cnt        <= cnt + CW'(1);
      i1         <= i1 + W'(s2);
      i2         <= i2 + i1;
      dout_valid <= 1'b0;
      if (tick_c) begin
        i2_d <= i2;
        c1_d <= c1_c;
        // The first two periods only prime the comb delay registers.
        if (warm != 2'd2) begin
          warm <= warm + 2'd1;
        end else begin
          dout       <= sat_c;
          dout_valid <= 1'b1;
        end
      end
    end
  end

endmodule
